// File: rtl/seg_led_scan.sv
// rtl/seg_led_scan.sv - multiplexed seven-segment scan driver with shadow registers
module seg_led_scan #(
  parameter int DIGITS         = 6,
  parameter int CLK_DIV        = 50000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int SEL_ACTIVE_LOW = 1
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     en_in,
  input  logic                  load,
  input  logic                  lz_blank,
  output logic [7:0]            seg_led,
  output logic [DIGITS-1:0]     seg_sel
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [7:0]        SEG_MASK = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] SEL_MASK = (SEL_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [4*DIGITS-1:0] data_q;
  logic [DIGITS-1:0]   dp_q;
  logic [DIGITS-1:0]   en_q;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   sel_q, sel_d;

  logic                slot_end;
  logic [3:0]          nib;
  logic                dp_bit;
  logic                en_bit;
  logic                zero_run;
  logic                lz_hit;
  logic [6:0]          glyph;
  logic [DIGITS-1:0]   sel_onehot;

  function automatic logic [6:0] glyph_of(input logic [3:0] n);
    case (n)
      4'h0: glyph_of = 7'h3F;
      4'h1: glyph_of = 7'h06;
      4'h2: glyph_of = 7'h5B;
      4'h3: glyph_of = 7'h4F;
      4'h4: glyph_of = 7'h66;
      4'h5: glyph_of = 7'h6D;
      4'h6: glyph_of = 7'h7D;
      4'h7: glyph_of = 7'h07;
      4'h8: glyph_of = 7'h7F;
      4'h9: glyph_of = 7'h6F;
      4'hA: glyph_of = 7'h77;
      4'hB: glyph_of = 7'h7C;
      4'hC: glyph_of = 7'h39;
      4'hD: glyph_of = 7'h5E;
      4'hE: glyph_of = 7'h79;
      default: glyph_of = 7'h71;
    endcase
  endfunction

  // Shadow copy of the display contents, refreshed whenever load is high
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      data_q <= '0;
      dp_q   <= '0;
      en_q   <= '0;
    end else if (load) begin
      data_q <= data_in;
      dp_q   <= dp_in;
      en_q   <= en_in;
    end
  end

  // Slot timer and digit index; the index steps on the last cycle of a slot
  always_comb begin
    slot_end = (cnt_q == CW'(CLK_DIV - 1));
    cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
    idx_d    = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  // Select the current digit's nibble and track the all-zero run from the top digit down
  always_comb begin
    nib        = 4'h0;
    dp_bit     = 1'b0;
    en_bit     = 1'b0;
    zero_run   = 1'b1;
    lz_hit     = 1'b0;
    sel_onehot = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (data_q[4*i +: 4] == 4'h0);
      if (idx_q == IW'(i)) begin
        nib           = data_q[4*i +: 4];
        dp_bit        = dp_q[i];
        en_bit        = en_q[i];
        lz_hit        = zero_run;
        sel_onehot[i] = 1'b1;
      end
    end
    glyph = glyph_of(nib);
    if (lz_blank && lz_hit && (idx_q != '0)) begin
      glyph = 7'h00;
    end
    // The last cycle of each slot is blanked so the select change never ghosts
    if (slot_end || !en_bit) begin
      seg_d = SEG_MASK;
      sel_d = SEL_MASK;
    end else begin
      seg_d = {dp_bit, glyph} ^ SEG_MASK;
      sel_d = sel_onehot ^ SEL_MASK;
    end
  end

  // Scan state and registered pin drivers
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_q <= '0;
      idx_q <= '0;
      seg_q <= SEG_MASK;
      sel_q <= SEL_MASK;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      sel_q <= sel_d;
    end
  end

  assign seg_led = seg_q;
  assign seg_sel = sel_q;

endmodule

// File: tb/tb_seg_led_scan.sv
// tb/tb_seg_led_scan.sv - table-driven bench for seg_led_scan
module tb_seg_led_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  en_in = '0;
  logic        load = 1'b0;
  logic        lz_blank = 1'b0;
  logic [7:0]  seg_led;
  logic [3:0]  seg_sel;

  logic [3:0]  data1 = 4'hE;
  logic        dp1 = 1'b0;
  logic        en1 = 1'b1;
  logic        load1 = 1'b1;
  logic        lz1 = 1'b0;
  logic [7:0]  seg_led1;
  logic        seg_sel1;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  seg_led_scan #(.DIGITS(4), .CLK_DIV(4), .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)) dut (
    .sys_clk(clk), .sys_rst(rst), .data_in(data_in), .dp_in(dp_in), .en_in(en_in),
    .load(load), .lz_blank(lz_blank), .seg_led(seg_led), .seg_sel(seg_sel)
  );

  seg_led_scan #(.DIGITS(1), .CLK_DIV(2), .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)) dut1 (
    .sys_clk(clk), .sys_rst(rst), .data_in(data1), .dp_in(dp1), .en_in(en1),
    .load(load1), .lz_blank(lz1), .seg_led(seg_led1), .seg_sel(seg_sel1)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  en;
    logic        lz;
    logic [31:0] leds;
    logic [15:0] sels;
  } vec_t;

  vec_t       vecs[7];
  logic [3:0] sel_on[4];

  task automatic check(input string name, input logic [7:0] got_led, input logic [7:0] exp_led,
                       input logic [3:0] got_sel, input logic [3:0] exp_sel);
    total++;
    if (got_led === exp_led && got_sel === exp_sel) passed++;
    else $display("FAIL %s (cyc %0d): seg_led=%h seg_sel=%h, expected %h/%h",
                  name, cyc, got_led, got_sel, exp_led, exp_sel);
  endtask

  task automatic load_vec(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en,
                          input logic lz);
    @(negedge clk);
    data_in  = d;
    dp_in    = dp;
    en_in    = en;
    lz_blank = lz;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_phase(input int modulus, input int val);
    for (int n = 0; n < 64 && (cyc % modulus) != val; n++) @(negedge clk);
    if ((cyc % modulus) != val) begin
      total++;
      $display("FAIL wait_phase: cyc%%%0d=%0d, expected %0d", modulus, cyc % modulus, val);
    end
  endtask

  initial begin
    vecs[0] = '{16'h1234, 4'h0, 4'hF, 1'b0, 32'hF9A4B099, 16'h7BDE};
    vecs[1] = '{16'h0070, 4'h0, 4'hF, 1'b1, 32'hFFFFF8C0, 16'h7BDE};
    vecs[2] = '{16'h0070, 4'h0, 4'hF, 1'b0, 32'hC0C0F8C0, 16'h7BDE};
    vecs[3] = '{16'hABCD, 4'h4, 4'hB, 1'b0, 32'h88FFC6A1, 16'h7FDE};
    vecs[4] = '{16'hABCD, 4'h2, 4'hB, 1'b0, 32'h88FF46A1, 16'h7FDE};
    vecs[5] = '{16'h0000, 4'h8, 4'hF, 1'b1, 32'h7FFFFFC0, 16'h7BDE};
    vecs[6] = '{16'h1000, 4'h0, 4'hF, 1'b1, 32'hF9C0C0C0, 16'h7BDE};
    sel_on  = '{4'hE, 4'hD, 4'hB, 4'h7};

    #2 rst = 1'b1;
    #2 check("reset_async", seg_led, 8'hFF, seg_sel, 4'hF);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check("idle_off", seg_led, 8'hFF, seg_sel, 4'hF);
    end

    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (((cyc - 1) % 2) == 0) check("d1_show", seg_led1, 8'h86, {3'b0, seg_sel1}, 4'h0);
      else                      check("d1_off", seg_led1, 8'hFF, {3'b0, seg_sel1}, 4'h1);
    end

    for (int v = 0; v < 7; v++) begin
      load_vec(vecs[v].data, vecs[v].dp, vecs[v].en, vecs[v].lz);
      for (int k = 0; k < 16; k++) begin
        int p;
        int slot;
        logic [31:0] l;
        logic [15:0] s;
        @(negedge clk);
        p    = (cyc - 1) % 16;
        slot = p / 4;
        l    = vecs[v].leds;
        s    = vecs[v].sels;
        if ((p % 4) == 3) check($sformatf("vec%0d_gap", v), seg_led, 8'hFF, seg_sel, 4'hF);
        else check($sformatf("vec%0d_d%0d", v, slot), seg_led, l[8*slot +: 8], seg_sel, s[4*slot +: 4]);
      end
    end

    load_vec(16'h0070, 4'h0, 4'hF, 1'b0);
    wait_phase(16, 13);
    check("lz_live_before", seg_led, 8'hC0, seg_sel, 4'h7);
    lz_blank = 1'b1;
    @(negedge clk);
    check("lz_live_after", seg_led, 8'hFF, seg_sel, 4'h7);

    load_vec(16'h1234, 4'h0, 4'hF, 1'b0);
    wait_phase(4, 3);
    data_in = 16'hFFFF;
    load    = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("wrap_load_off", seg_led, 8'hFF, seg_sel, 4'hF);
    @(negedge clk);
    check("wrap_load_next", seg_led, 8'h8E, seg_sel, sel_on[((cyc - 1) % 16) / 4]);

    wait_phase(4, 1);
    data_in = 16'h5555;
    load    = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("latency_old", seg_led, 8'h8E, seg_sel, sel_on[((cyc - 1) % 16) / 4]);
    @(negedge clk);
    check("latency_new", seg_led, 8'h92, seg_sel, sel_on[((cyc - 1) % 16) / 4]);

    @(negedge clk);
    rst = 1'b1;
    #1;
    check("reset_mid", seg_led, 8'hFF, seg_sel, 4'hF);
    check("reset_mid_d1", seg_led1, 8'hFF, {3'b0, seg_sel1}, 4'h1);
    @(negedge clk);
    rst = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
